// File: rtl/gate_truth_table_tester.sv
// gate_truth_table_tester
//   Self-test sequencer for a 2-input combinational gate. It steps {a,b}
//   through 00,01,10,11. Each vector is held for SETTLE_CYCLES+1 cycles.
//   The gate output y is sampled on the last edge of each vector and
//   compared against EXPECT_TT[{a,b}].
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   begin a run (accepted only while idle)
//   y         in   output of the gate under test
//   a, b      out  gate inputs (vector bit 1 / bit 0)
//   busy      out  high while a run is in progress
//   done      out  one-cycle pulse at run completion
//   pass      out  last run had no mismatches
//   err_mask  out  bit k set when vector k mismatched
//   err_count out  number of mismatched vectors (popcount of err_mask)
module gate_truth_table_tester #(
    parameter logic [3:0]  EXPECT_TT     = 4'b1000,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_mask,
    output logic [2:0] err_count
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_t     state_q, state_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] err_mask_q, err_mask_d;
    logic [2:0] err_count_q, err_count_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;

    // Result of the compare that would happen if this edge is a sample edge.
    logic       mismatch;
    logic [3:0] sample_mask;
    logic [2:0] sample_count;
    logic [1:0] vec_next;

    always_comb begin
        mismatch     = (y != EXPECT_TT[vec_q]);
        sample_mask  = err_mask_q | (mismatch ? (4'b0001 << vec_q) : 4'b0000);
        sample_count = err_count_q + {2'b00, mismatch};
        vec_next     = vec_q + 2'd1;

        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_mask_d  = err_mask_q;
        err_count_d = err_count_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                a_d    = 1'b0;
                b_d    = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    err_mask_d  = '0;
                    err_count_d = '0;
                    pass_d      = 1'b0;
                    vec_d       = '0;
                    cnt_d       = SETTLE_INIT;
                    busy_d      = 1'b1;
                    state_d     = APPLY;
                end
            end
            APPLY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    err_mask_d  = sample_mask;
                    err_count_d = sample_count;
                    if (vec_q == 2'd3) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        // pass must include this final sample, hence sample_mask
                        pass_d  = (sample_mask == '0);
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                        vec_d   = '0;
                    end else begin
                        vec_d = vec_next;
                        a_d   = vec_next[1];
                        b_d   = vec_next[0];
                        cnt_d = SETTLE_INIT;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_mask_q  <= '0;
            err_count_q <= '0;
            vec_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_mask_q  <= err_mask_d;
            err_count_q <= err_count_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_mask  = err_mask_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_gate_truth_table_tester.sv
module tb_gate_truth_table_tester;

    typedef struct {
        int unsigned done_cyc;
        logic [3:0]  mask;
        logic [2:0]  cnt;
        logic        pass;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;

    // Instance 0: default settle time; instance 1: SETTLE_CYCLES=0.
    logic       start0 = 1'b0, start1 = 1'b0;
    logic       y0, y1;
    logic       a0, b0, busy0, done0, pass0;
    logic       a1, b1, busy1, done1, pass1;
    logic [3:0] mask0, mask1;
    logic [2:0] cnt0, cnt1;

    int   mode0 = 0;      // 0 AND, 1 OR, 2 stuck-at-0
    logic flip11 = 1'b0;  // instance 1: invert y for vector 11
    logic glitch_en = 1'b0;
    logic glitch = 1'b0;

    always_comb begin
        y0 = (mode0 == 1) ? (a0 | b0) : (mode0 == 2) ? 1'b0 : (a0 & b0);
        y1 = ((a1 & b1) ^ (flip11 & a1 & b1)) ^ glitch;
    end

    // y1 is wrong shortly after each rising edge, correct again before the next.
    initial forever begin
        @(posedge clk);
        #1 glitch = glitch_en;
        #3 glitch = 1'b0;
    end

    gate_truth_table_tester dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .y(y0),
        .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .err_mask(mask0), .err_count(cnt0)
    );

    gate_truth_table_tester #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start1), .y(y1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_mask(mask1), .err_count(cnt1)
    );

    res_t       rq0[$], rq1[$];
    logic [1:0] abq0[$], abq1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: unexpected DUT event (cycle %0d)", name, cyc);
    endtask

    // Monitors: pop the expected a/b per busy cycle and the result per done pulse.
    always @(negedge clk) if (rst_n) begin
        res_t r;
        if (busy0) begin
            if (abq0.size() == 0) unexpected("ab0");
            else chk("ab0", {30'd0, a0, b0}, {30'd0, abq0.pop_front()});
        end
        if (done0) begin
            if (rq0.size() == 0) unexpected("done0");
            else begin
                r = rq0.pop_front();
                chk("done0_cycle", cyc, r.done_cyc);
                chk("mask0", {28'd0, mask0}, {28'd0, r.mask});
                chk("count0", {29'd0, cnt0}, {29'd0, r.cnt});
                chk("pass0", {31'd0, pass0}, {31'd0, r.pass});
                chk("busy0_at_done", {31'd0, busy0}, 32'd0);
            end
        end
    end

    always @(negedge clk) if (rst_n) begin
        res_t r;
        if (busy1) begin
            if (abq1.size() == 0) unexpected("ab1");
            else chk("ab1", {30'd0, a1, b1}, {30'd0, abq1.pop_front()});
        end
        if (done1) begin
            if (rq1.size() == 0) unexpected("done1");
            else begin
                r = rq1.pop_front();
                chk("done1_cycle", cyc, r.done_cyc);
                chk("mask1", {28'd0, mask1}, {28'd0, r.mask});
                chk("count1", {29'd0, cnt1}, {29'd0, r.cnt});
                chk("pass1", {31'd0, pass1}, {31'd0, r.pass});
            end
        end
    end

    // Issue start so it is sampled at the next rising edge (E0); returns E0.
    task automatic start_run0(input logic [3:0] mask, input logic [2:0] cnt,
                              input logic pass, output int unsigned e0);
        @(negedge clk);
        e0 = cyc + 1;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 3; j++) abq0.push_back(2'(k));
        rq0.push_back('{done_cyc: e0 + 12, mask: mask, cnt: cnt, pass: pass});
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic start_run1(input logic [3:0] mask, input logic [2:0] cnt,
                              input logic pass);
        int unsigned e0;
        @(negedge clk);
        e0 = cyc + 1;
        for (int k = 0; k < 4; k++) abq1.push_back(2'(k));
        rq1.push_back('{done_cyc: e0 + 4, mask: mask, cnt: cnt, pass: pass});
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic wait_empty(input int inst);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (inst == 0 && rq0.size() == 0) return;
            if (inst == 1 && rq1.size() == 0) return;
        end
        unexpected(inst == 0 ? "timeout0" : "timeout1");
        rq0.delete(); abq0.delete(); rq1.delete(); abq1.delete();
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_0"}, {21'd0, a0, b0, busy0, done0, pass0, mask0, cnt0}, 32'd0);
        chk({name, "_1"}, {21'd0, a1, b1, busy1, done1, pass1, mask1, cnt1}, 32'd0);
    endtask

    initial begin
        int unsigned e0;
        #12;
        chk_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good AND gate.
        mode0 = 0;
        start_run0(4'b0000, 3'd0, 1'b1, e0);
        wait_empty(0);
        @(negedge clk);
        chk("idle_busy_after", {31'd0, busy0}, 32'd0);

        // Stuck-at-0 gate; results must hold after done.
        mode0 = 2;
        start_run0(4'b1000, 3'd1, 1'b0, e0);
        wait_empty(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_result", {24'd0, pass0, mask0, cnt0}, {24'd0, 1'b0, 4'b1000, 3'd1});
        end

        // OR gate with AND expectation; stray start at E4 is ignored.
        mode0 = 1;
        start_run0(4'b0110, 3'd2, 1'b0, e0);
        while (cyc != e0 + 3) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_empty(0);

        // Rerun with a good gate clears prior errors.
        mode0 = 0;
        start_run0(4'b0000, 3'd0, 1'b1, e0);
        wait_empty(0);

        // Reset mid-cycle during vector 2 aborts without reporting.
        mode0 = 2;
        start_run0(4'b1000, 3'd1, 1'b0, e0);
        while (cyc != e0 + 7) @(negedge clk);
        #1;
        chk("ab_before_abort", {30'd0, a0, b0}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        rq0.delete(); abq0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        mode0 = 0;
        start_run0(4'b0000, 3'd0, 1'b1, e0);
        wait_empty(0);

        // Zero settle time: y wrong only away from sample edges -> pass.
        glitch_en = 1'b1;
        start_run1(4'b0000, 3'd0, 1'b1);
        wait_empty(1);
        glitch_en = 1'b0;
        // y wrong on the vector-3 sample edge.
        flip11 = 1'b1;
        start_run1(4'b1000, 3'd1, 1'b0);
        wait_empty(1);
        flip11 = 1'b0;

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_truth_table_tester.md
Name: gate_truth_table_tester

Overview:
- Self-test sequencer for a 2-input combinational gate under test, such as the project's and_gate.
- Upstream, it drives the gate's a/b inputs through all four input combinations, holding each for a programmable settle time.
- Downstream, it samples the gate's y output and compares it against an expected truth table.
- It reports a per-vector error mask, an error count and a pass flag, so gate checks run on the FPGA without a simulator.

Parameters:
- EXPECT_TT, 4'b1000: expected y for each vector, indexed by {a,b}; the default is the AND truth table.
- SETTLE_CYCLES, 2: number of extra clock cycles each vector is held before y is sampled. Legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a test run; sampled only in IDLE.
- y  input  1  output of the gate under test.
- a  output  1  gate input A; equals vector bit 1.
- b  output  1  gate input B; equals vector bit 0.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse when a run completes.
- pass  output  1  1 when the last run had zero mismatches.
- err_mask  output  4  bit k set when vector k mismatched.
- err_count  output  3  number of mismatched vectors (0..4).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, applied asynchronously): state=IDLE, a=0, b=0, busy=0, done=0, pass=0, err_mask=0, err_count=0, vec=0, settle counter=0.
- All outputs are registered.
- States: IDLE, APPLY, DONE.
- IDLE:
  - a=b=0, busy=0.
  - start=1 at edge E0: clear err_mask, err_count and pass; set vec=0, {a,b}=2'b00, cnt=SETTLE_CYCLES, busy=1; go to APPLY.
- APPLY, each edge:
  - If cnt!=0: cnt decrements; a/b hold.
  - If cnt==0, this is the sample edge:
    - Compare y with EXPECT_TT[vec]. On mismatch, set err_mask[vec] and increment err_count.
    - If vec==3: go to DONE; busy<=0; done<=1; pass<=(no mismatch in the run, including this sample); a,b<=0.
    - Else: vec<=vec+1; {a,b}<=vec+1; cnt<=SETTLE_CYCLES.
- Timing:
  - Each vector is driven for SETTLE_CYCLES+1 cycles.
  - Vector k is applied at edge E0+k*(SETTLE_CYCLES+1).
  - Vector k is sampled at edge E0+(k+1)*(SETTLE_CYCLES+1).
  - done rises at edge E0+4*(SETTLE_CYCLES+1).
  - Default timing: samples at E3, E6, E9, E12; done high for the cycle after E12.
- y is observed only on sample edges; its value at any other time has no effect.
- DONE: lasts one cycle; done returns to 0 and the state goes to IDLE on the next edge.
- Result hold: pass, err_mask and err_count hold until the next accepted start.
- start while busy (APPLY or DONE) is ignored; no restart and no queuing.
- start held high continuously starts a new run on the first IDLE edge after DONE.
- Reset asserted mid-run aborts immediately. All outputs return to reset values, and a partial result is never reported.
- err_count always equals the popcount of err_mask. It cannot overflow, since the maximum is 4.
- SETTLE_CYCLES=0: one cycle per vector; done rises 4 edges after E0.

Test Plan:
- Bench AND model, defaults: pulse start at E0 -> a/b sequence 00,01,10,11, each held 3 cycles; done at E12 for 1 cycle; pass=1, err_mask=0000, err_count=0, busy low after E12.
- y stuck at 0 -> err_mask=1000, err_count=1, pass=0; results stay stable for 5 cycles after done.
- OR gate connected with default EXPECT_TT -> err_mask=0110, err_count=2, pass=0.
- Pulse start at E4 during a run -> no restart; done still at E12. A second start after done clears prior errors, and the rerun on a good gate gives pass=1.
- Assert rst_n=0 mid-cycle during vector 2 -> a, b, busy, done, pass, err_mask and err_count go to 0 immediately, without waiting for a clock edge. After release, start completes a normal run.
- SETTLE_CYCLES=0 with y forced wrong only on non-sample cycles -> done 4 edges after start, pass=1. y wrong on the vector-3 sample edge -> err_mask=1000.
